// File: rtl/uart_byte_rx_if.sv
// Signal bundle between the UART receive engine and its consumer: serial line,
// rate select, received byte and status.
`timescale 1ns/1ps
interface uart_byte_rx_if;
    logic [2:0] baud_set;
    logic       rs232_rx;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       parity_err;
    logic       uart_state;

    // master: the receive engine; slave: the line driver / byte consumer
    modport master (
        input  baud_set, rs232_rx,
        output data_byte, rx_done, frame_err, parity_err, uart_state
    );
    modport slave (
        output baud_set, rs232_rx,
        input  data_byte, rx_done, frame_err, parity_err, uart_state
    );
endinterface

// File: rtl/uart_byte_rx.sv
// UART receive engine: 16x oversampled 8N1 (8E1 with UART_RX_PARITY_EN defined) byte
// recovery with 2-of-3 majority sampling and a one-cycle rx_done strobe.
`timescale 1ns/1ps
module uart_byte_rx #(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic           clk,
    input  logic           rst_n,
    uart_byte_rx_if.master rx
);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
`ifdef UART_RX_PARITY_EN
        StParity,
`endif
        StStop
    } state_e;

`ifdef UART_RX_PARITY_EN
    localparam logic [3:0] StopIdx = 4'd10;
`else
    localparam logic [3:0] StopIdx = 4'd9;
`endif

    // Divider table is tuned for 50 MHz; other clocks scale it linearly.
    localparam int unsigned ClkScale = CLK_FREQ / 10_000;
    localparam logic [15:0] Dr9600   = 16'((324 * ClkScale) / 5_000);
    localparam logic [15:0] Dr19200  = 16'((162 * ClkScale) / 5_000);
    localparam logic [15:0] Dr38400  = 16'((80 * ClkScale) / 5_000);
    localparam logic [15:0] Dr57600  = 16'((53 * ClkScale) / 5_000);
    localparam logic [15:0] Dr115200 = 16'((26 * ClkScale) / 5_000);

    state_e      state_q, state_d;
    logic        rx_s1_q, rx_s2_q, rx_s3_q;
    logic        fall_edge;
    logic [2:0]  baud_q;
    logic [15:0] bps_dr;
    logic [15:0] div_cnt_q;
    logic        bps_clk;
    logic [7:0]  t_q;
    logic        tick_q;
    logic [1:0]  samp_q;
    logic        majority;
    logic        decide;
    logic [3:0]  bit_idx;
    logic [2:0]  data_idx;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        frame_err_q, frame_err_d;
    logic        rx_done_q, rx_done_d;
`ifdef UART_RX_PARITY_EN
    logic        par_bit_q, par_bit_d;
    logic        parity_err_q, parity_err_d;
`endif

    assign fall_edge = rx_s3_q & ~rx_s2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q <= 1'b1;
            rx_s2_q <= 1'b1;
            rx_s3_q <= 1'b1;
        end else begin
            rx_s1_q <= rx.rs232_rx;
            rx_s2_q <= rx_s1_q;
            rx_s3_q <= rx_s2_q;
        end
    end

    always_comb begin
        case (baud_q)
            3'd1:    bps_dr = Dr19200;
            3'd2:    bps_dr = Dr38400;
            3'd3:    bps_dr = Dr57600;
            3'd4:    bps_dr = Dr115200;
            default: bps_dr = Dr9600;
        endcase
    end

    assign bps_clk = (state_q != StIdle) && (div_cnt_q == bps_dr);

    // tick_q marks the first cycle in which t_q holds a freshly reached tick number
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q    <= 3'd0;
            div_cnt_q <= 16'd0;
            t_q       <= 8'd0;
            tick_q    <= 1'b0;
            samp_q    <= 2'b11;
        end else if (state_q == StIdle) begin
            div_cnt_q <= 16'd0;
            t_q       <= 8'd0;
            tick_q    <= 1'b0;
            if (fall_edge) begin
                baud_q <= rx.baud_set;
            end
        end else begin
            tick_q <= bps_clk;
            if (bps_clk) begin
                div_cnt_q <= 16'd0;
                t_q       <= t_q + 8'd1;
            end else begin
                div_cnt_q <= div_cnt_q + 16'd1;
            end
            if (tick_q && (t_q[3:0] == 4'd7 || t_q[3:0] == 4'd8)) begin
                samp_q <= {samp_q[0], rx_s2_q};
            end
        end
    end

    // Third sample is the live synchronized line at tick 16b+9
    assign majority = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_s2_q) | (samp_q[0] & rx_s2_q);
    assign decide   = tick_q && (t_q[3:0] == 4'd9);
    assign bit_idx  = t_q[7:4];
    assign data_idx = 3'(bit_idx - 4'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            shift_q      <= 8'h00;
            data_q       <= 8'h00;
            frame_err_q  <= 1'b0;
            rx_done_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            frame_err_q  <= frame_err_d;
            rx_done_q    <= rx_done_d;
`ifdef UART_RX_PARITY_EN
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
`endif
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        data_d       = data_q;
        frame_err_d  = frame_err_q;
        rx_done_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bit_d    = par_bit_q;
        parity_err_d = parity_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (fall_edge) state_d = StStart;
            end
            StStart: begin
                if (decide) state_d = majority ? StIdle : StData;
            end
            StData: begin
                if (decide) begin
                    shift_d[data_idx] = majority;
                    if (bit_idx == 4'd8) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (decide) begin
                    par_bit_d = majority;
                    state_d   = StStop;
                end
            end
`endif
            StStop: begin
                if (decide && bit_idx == StopIdx) begin
                    data_d       = shift_q;
                    frame_err_d  = ~majority;
`ifdef UART_RX_PARITY_EN
                    parity_err_d = ^{shift_q, par_bit_q};
`endif
                    rx_done_d    = 1'b1;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign rx.data_byte  = data_q;
    assign rx.rx_done    = rx_done_q;
    assign rx.frame_err  = frame_err_q;
    assign rx.uart_state = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
    assign rx.parity_err = parity_err_q;
`else
    assign rx.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed bench for uart_byte_rx: serial frames in, scoreboard of expected bytes/flags out.
`timescale 1ns/1ps
module tb_uart_byte_rx;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    uart_byte_rx_if bus ();

    uart_byte_rx #(
        .CLK_FREQ(50_000_000)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (bus)
    );

`ifdef UART_RX_PARITY_EN
    localparam int StopIdx = 10;
    logic par_inv = 1'b0;
`else
    localparam int StopIdx = 9;
`endif

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    exp_t sb_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   start_cyc   = 0;
    int   done_cyc    = 0;
    int   n_done      = 0;
    logic prev_done   = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t mk(input logic [7:0] d, input logic f, input logic p);
        exp_t e;
        e.data = d;
        e.ferr = f;
        e.perr = p;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every rx_done pops one expected frame
    always @(negedge clk) begin
        if (prev_done) check("rx_done_width", 32'(bus.rx_done), 32'd0);
        if (bus.rx_done === 1'b1) begin
            done_cyc = cyc;
            n_done++;
            if (sb_q.size() == 0) begin
                check("rx_done_unexpected", 32'(bus.rx_done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("data_byte", 32'(bus.data_byte), 32'(e.data));
                check("frame_err", 32'(bus.frame_err), 32'(e.ferr));
                check("parity_err", 32'(bus.parity_err), 32'(e.perr));
            end
        end
        prev_done = bus.rx_done;
    end

    task automatic send_frame(input logic [7:0] d, input logic stop_bit, input int bit_ns);
        @(negedge clk);
        start_cyc = cyc;
        bus.rs232_rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            bus.rs232_rx = d[i];
            #(bit_ns);
        end
`ifdef UART_RX_PARITY_EN
        bus.rs232_rx = (^d) ^ par_inv;
        #(bit_ns);
`endif
        bus.rs232_rx = stop_bit;
        #(bit_ns);
        bus.rs232_rx = 1'b1;
    endtask

    task automatic wait_done(input int target, input string tag);
        int guard;
        guard = 0;
        while (n_done < target && guard < 20000) begin
            @(posedge clk);
            guard++;
        end
        #1;
        check(tag, 32'(n_done), 32'(target));
    endtask

    initial begin
        int c0;
        bus.rs232_rx = 1'b1;
        bus.baud_set = 3'd4;
        rst_n        = 1'b1;
        #5 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_byte", 32'(bus.data_byte), 32'h00);
        check("rst_rx_done", 32'(bus.rx_done), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);
        check("rst_uart_state", 32'(bus.uart_state), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // 0xA5 at 115200, latency from pin edge = 3 sync clocks + StopTicks*27 + 1
        sb_q.push_back(mk(8'hA5, 1'b0, 1'b0));
        send_frame(8'hA5, 1'b1, 8681);
        wait_done(1, "a5_done_count");
        check("a5_latency", 32'(done_cyc - start_cyc), 32'(3 + (16 * StopIdx + 9) * 27 + 1));

        // Back-to-back at 38400
        bus.baud_set = 3'd2;
        sb_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        sb_q.push_back(mk(8'hC3, 1'b0, 1'b0));
        send_frame(8'h3C, 1'b1, 26042);
        send_frame(8'hC3, 1'b1, 26042);
        wait_done(3, "b2b_done_count");

        // 2 us glitch at 9600: busy from edge+3 until start tick 9 decision
        bus.baud_set = 3'd0;
        @(negedge clk);
        c0 = cyc;
        bus.rs232_rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("sync_latency_pre", 32'(bus.uart_state), 32'd0);
        @(posedge clk);
        #1;
        check("sync_latency_busy", 32'(bus.uart_state), 32'd1);
        #1930;
        bus.rs232_rx = 1'b1;
        while (bus.uart_state && (cyc - c0) < 6000) begin
            @(posedge clk);
            #1;
        end
        check("false_start_release", 32'(cyc - c0), 32'(3 + 9 * 325 + 1));
        repeat (500) @(posedge clk);
        check("false_start_no_done", 32'(n_done), 32'd3);

        // Stop bit low at 57600, then a clean frame clears frame_err
        bus.baud_set = 3'd3;
        sb_q.push_back(mk(8'h55, 1'b1, 1'b0));
        send_frame(8'h55, 1'b0, 17361);
        wait_done(4, "ferr_done_count");
        #17361;
        sb_q.push_back(mk(8'h0F, 1'b0, 1'b0));
        send_frame(8'h0F, 1'b1, 17361);
        wait_done(5, "clean_done_count");

        // Reset during data bit 4 of 0xFF at 115200
        bus.baud_set = 3'd4;
        fork
            send_frame(8'hFF, 1'b1, 8681);
            begin
                #(20 + 8681 * 4 + 4340);
                rst_n = 1'b0;
                #1;
                check("midrst_data_byte", 32'(bus.data_byte), 32'h00);
                check("midrst_uart_state", 32'(bus.uart_state), 32'd0);
                check("midrst_frame_err", 32'(bus.frame_err), 32'd0);
                check("midrst_rx_done", 32'(bus.rx_done), 32'd0);
                #100;
                rst_n = 1'b1;
            end
        join
        repeat (2000) @(posedge clk);
        check("midrst_no_done", 32'(n_done), 32'd5);
        sb_q.push_back(mk(8'h81, 1'b0, 1'b0));
        send_frame(8'h81, 1'b1, 8681);
        wait_done(6, "post_rst_done_count");

`ifdef UART_RX_PARITY_EN
        // 0x07 has odd weight: parity bit 0 is a mismatch, 1 is correct
        par_inv = 1'b1;
        sb_q.push_back(mk(8'h07, 1'b0, 1'b1));
        send_frame(8'h07, 1'b1, 8681);
        wait_done(7, "par_bad_done_count");
        par_inv = 1'b0;
        sb_q.push_back(mk(8'h07, 1'b0, 1'b0));
        send_frame(8'h07, 1'b1, 8681);
        wait_done(8, "par_good_done_count");
`endif

        repeat (100) @(posedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_byte_rx.md
# uart_byte_rx

UART receive engine for the UART block: recovers 8N1 bytes (8E1 when parity is compiled in) from the asynchronous `rs232_rx` line, using 16x oversampling on a 50 MHz `clk`. Baud rate comes from the same `baud_set` encoding the transmit side uses, through an internal oversampling divider table. It is the far end of the link driven by the UART transmitter. It delivers one byte per frame with a single-cycle `rx_done` strobe.

## Interface
- `CLK_FREQ`, 50_000_000, system clock in Hz; documents the divider table values.
- `clk`  in  1  system clock, 50 MHz.
- `rst_n`  in  1  asynchronous, active-low reset.
- `baud_set`  in  3  rate select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200, 5–7=9600.
- `rs232_rx`  in  1  serial line; idles high; asynchronous to `clk`.
- `data_byte`  out  8  last received byte, LSB first on the line; holds until the next frame completes.
- `rx_done`  out  1  one-cycle pulse when `data_byte` and the error flags update.
- `frame_err`  out  1  stop bit sampled low; valid with `rx_done`; held until the next `rx_done`.
- `parity_err`  out  1  even-parity mismatch; valid with `rx_done`; constant 0 without `UART_RX_PARITY_EN`.
- `uart_state`  out  1  high from start-edge detection until the frame ends (busy).

## Operation
- Synchronizer: two flip-flops on `rs232_rx`, plus one extra register for edge detection. A falling edge is registered high-to-low on the synchronized line.
- Divider terminal values (`bps_DR`, tick every `bps_DR`+1 clocks):
  - 9600 → 324
  - 19200 → 162
  - 38400 → 80
  - 57600 → 53
  - 115200 → 26
- `baud_set` is latched on start-edge detection. Changes mid-frame have no effect.
- `div_cnt` (16 bit) is held at 0 in IDLE. Otherwise it counts 0..`bps_DR`, then wraps. `bps_clk` pulses for one cycle on the wrap.
- Tick counter `t` (8 bit) is cleared in IDLE and increments per `bps_clk`. Bit b (start=0, data 1–8, [parity 9], stop last) spans ticks 16b+1..16b+16.
- Sampling: the line is sampled at ticks 16b+7, +8, +9. A 2-of-3 majority gives the bit value, decided at tick 16b+9.
- States:
  - IDLE: on falling edge → START; `uart_state`=1.
  - START: at tick 9, majority 1 → false start, back to IDLE, no `rx_done`; majority 0 → DATA.
  - DATA: shift the decided bit into bit[b-1] of a shift register; after bit 8 → PARITY if enabled, else STOP.
  - PARITY: store the decided bit.
  - STOP: at tick 16·S+9, where S is the stop index (9, or 10 with parity):
    - copy the shift register to `data_byte`
    - set `frame_err` = !majority
    - set `parity_err` = XOR(data, parity bit)
    - pulse `rx_done` next cycle; go to IDLE; `uart_state`=0 on the same edge.
- Returning to IDLE mid-stop-bit allows immediate resync on the next start edge.
- A falling edge while not in IDLE is ignored.
- A break condition (line held low) produces a frame with data 0x00 and `frame_err`=1. No new frame starts until the line goes high and then falls again.

## Timing
- Reset values:
  - `data_byte`=0x00, `rx_done`=0, `frame_err`=0, `parity_err`=0, `uart_state`=0
  - internal counters 0, state IDLE, synchronizer registers 1
- Reset asserted mid-frame aborts the frame immediately. No `rx_done` is produced.
- Pin falling edge → `uart_state` high: 3 clocks.
- Start detection → `rx_done`: (153·(`bps_DR`+1)) + 1 clocks for 8N1; (169·(`bps_DR`+1)) + 1 clocks for 8E1. At 115200 8N1 this is 4132 clocks.
- `rx_done` is exactly one cycle wide. Back-to-back frames produce one pulse each.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - frame is 8E1 (start, 8 data, even parity, stop)
  - stop index 10
  - `parity_err` is live
- Not defined:
  - frame is 8N1
  - stop index 9
  - the PARITY state and parity logic are not built
  - `parity_err` is tied to 0

## Test plan
- `baud_set`=4, send 0xA5 8N1 at 115200 (8680 ns/bit) → one `rx_done`, `data_byte`=0xA5, `frame_err`=0, `rx_done` 4132±3 clocks after the pin falling edge.
- `baud_set`=2, send 0x3C then immediately 0xC3 with a single stop bit → two `rx_done` pulses, values 0x3C then 0xC3.
- Line low for 2 µs at 9600, then high → `uart_state` pulses high and returns low at start tick 9, no `rx_done`.
- Send 0x55 with the stop bit forced low at 57600 → `rx_done` with `data_byte`=0x55, `frame_err`=1. The next clean frame 0x0F clears `frame_err`.
- Assert `rst_n`=0 during data bit 4 of 0xFF → all outputs return to reset values, no `rx_done`. A following 0x81 is received correctly.
- With `UART_RX_PARITY_EN`, send 0x07 with parity bit 0 → `parity_err`=1. With parity bit 1 → `parity_err`=0.
